sync_err_recovery_seq: RTL
==========================

Name: sync_err_recovery_seq

Overview:
Sequences automatic recovery from latched synchronization errors. It watches the OR'd sync_err flag from the sync error control block, waits a programmable holdoff, then issues a one-cycle sync error reset back into that block. It bounds the number of retries, declares a sticky failure when the bound is exceeded, and records error statistics for VME readout. It sits between the sync error control block and the VME register file.

Parameters:
HOLD_BITS, 12, width of holdoff counter and holdoff_cnt input
RETRY_BITS, 4, width of retry counter and max_retries input
SETTLE_CYCLES, 16, cycles after an auto reset during which sync_err is ignored (>=2)
CLEAN_BITS, 16, width of clean-period counter; 2^CLEAN_BITS-1 consecutive error-free IDLE cycles clear retry_count

Ports:
clock  in  1  main 40MHz clock
reset_n  in  1  asynchronous active-low reset
ttc_resync  in  1  TTC resync; synchronous clear of sequencer
vme_clear  in  1  VME clear of fail flag and statistics
sync_err  in  1  latched sync error from sync error control
bxn_counter  in  12  current bunch crossing number
auto_recover_en  in  1  enable automatic recovery
holdoff_cnt  in  HOLD_BITS  HOLD duration minus 1
max_retries  in  RETRY_BITS  auto resets allowed before FAIL
auto_sync_err_reset  out  1  one-cycle reset pulse to sync error control
recover_busy  out  1  state is HOLD, RESET or SETTLE
recover_fail  out  1  sticky: retries exhausted
retry_count  out  RETRY_BITS  auto resets issued since last clean period or clear
err_event_cnt  out  8  sync_err rising edges, saturating at 255
first_err_bxn  out  12  bxn_counter at first sync_err rise since clear
first_err_valid  out  1  first_err_bxn holds a capture
seq_state  out  3  FSM state for VME: IDLE=0, HOLD=1, RESET=2, SETTLE=3, FAIL=4

Behaviour:
- Reset (reset_n=0, asynchronous): all outputs 0, state IDLE, all internal counters 0, sync_err edge register 0. All outputs are registered.
- Priority: reset_n > ttc_resync > vme_clear > FSM.
- ttc_resync: state to IDLE; hold, settle and clean counters to 0; retry_count 0; recover_fail 0; first_err_valid 0; no pulse. err_event_cnt is retained.
- vme_clear: same as ttc_resync, and also clears err_event_cnt and first_err_bxn.
- Edge detect: a rise is sync_err=1 with the previous-cycle sample 0.
  - On each rise, err_event_cnt increments, saturating at 255.
  - If first_err_valid=0 on a rise, capture bxn_counter into first_err_bxn and set first_err_valid the next cycle.
  - Edges are counted in every state, including SETTLE.
- IDLE:
  - sync_err=1 and auto_recover_en=1 and retry_count>=max_retries: go to FAIL and set recover_fail.
  - sync_err=1 and auto_recover_en=1 and retry_count<max_retries: go to HOLD and load the hold counter with holdoff_cnt.
  - sync_err=0: the clean counter increments. When it reaches all-ones, retry_count clears to 0 and the clean counter restarts. Any sync_err=1 zeroes the clean counter.
  - auto_recover_en=0: remain in IDLE.
- HOLD:
  - Decrement the hold counter. When it is 0, go to RESET. HOLD therefore lasts holdoff_cnt+1 cycles.
  - If sync_err falls (external VME reset) or auto_recover_en drops: return to IDLE with no pulse and no retry increment.
- RESET:
  - Lasts exactly 1 cycle. auto_sync_err_reset=1 during the cycle the state is RESET; the output is registered from the next-state decode, so the pulse aligns with seq_state=2.
  - retry_count increments, saturating.
  - Next state is SETTLE with the settle counter loaded to SETTLE_CYCLES-1.
- SETTLE:
  - sync_err is ignored for FSM purposes. Decrement to 0, then go to IDLE.
  - If sync_err is still or again 1 on return, the IDLE rules apply on the next cycle.
- FAIL:
  - Absorbing state: no pulses, recover_fail=1, recover_busy=0. Exits only on ttc_resync or vme_clear.
- max_retries=0 with auto_recover_en=1: the first error goes directly to FAIL.
- holdoff_cnt changes while in HOLD take effect only at the next load.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE..FAIL, 3 bits);
  - the err_event_cnt width (8) and its saturation value.
- One natural sub-module, sat_counter: a generic width-parameterised saturating incrementer with synchronous clear, used for retry_count, err_event_cnt and the clean counter.
- The FSM and the down-counters stay in the top level.

Test Plan:
- holdoff_cnt=3, max_retries=2, auto_recover_en=1; raise sync_err at bxn 0x123 -> 4 HOLD cycles, 1-cycle pulse, retry_count=1, first_err_bxn=0x123, first_err_valid=1, err_event_cnt=1.
- sync_err held high through 3 recovery attempts with max_retries=2 -> exactly 2 pulses, then FAIL with recover_fail=1, seq_state=4, and no further pulses until ttc_resync.
- Drop sync_err during HOLD (holdoff_cnt=100, drop at cycle 10) -> IDLE, no pulse, retry_count unchanged.
- CLEAN_BITS=4 after 1 retry; sync_err=0 for 15 IDLE cycles -> retry_count returns to 0. A glitch at cycle 8 restarts the count.
- Drive 300 sync_err rises -> err_event_cnt saturates at 255. ttc_resync keeps 255; vme_clear gives 0.
- Deassert reset_n mid-SETTLE and mid-pulse -> all outputs 0 asynchronously, IDLE after release. Simultaneous ttc_resync and sync_err rise -> clear wins, but the edge is still counted.

Source files
------------

// File: rtl/sync_err_recovery_seq_pkg.sv
// Shared definitions for the sync error recovery sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sync_err_recovery_seq_pkg;

    // Sequencer states; the numeric values are what VME software reads back.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HOLD   = 3'd1,
        ST_RESET  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_FAIL   = 3'd4
    } seq_state_t;

    // Error event statistics counter width and its saturation value.
    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/sync_err_recovery_seq_sat_counter.sv
// Generic saturating up-counter with synchronous clear (clear beats increment).
// Latency: count updates on the clock edge after clr/inc.
// Backpressure: none; increments past MAX_VAL are dropped.
module sat_counter #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Clear has priority; otherwise step up until the ceiling is reached.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX_VAL)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sync_err_recovery_seq.sv
// Automatic recovery sequencer: holdoff, one-cycle sync error reset, settle, bounded retries.
// Latency: all outputs registered; pulse issued holdoff_cnt+2 cycles after sync_err is seen.
// Backpressure: none; sync_err is level-sampled, edges are counted in every state.
module sync_err_recovery_seq
    import sync_err_recovery_seq_pkg::*;
#(
    parameter int HOLD_BITS     = 12,
    parameter int RETRY_BITS    = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int CLEAN_BITS    = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  ttc_resync,
    input  logic                  vme_clear,
    input  logic                  sync_err,
    input  logic [11:0]           bxn_counter,
    input  logic                  auto_recover_en,
    input  logic [HOLD_BITS-1:0]  holdoff_cnt,
    input  logic [RETRY_BITS-1:0] max_retries,
    output logic                  auto_sync_err_reset,
    output logic                  recover_busy,
    output logic                  recover_fail,
    output logic [RETRY_BITS-1:0] retry_count,
    output logic [ERR_CNT_W-1:0]  err_event_cnt,
    output logic [11:0]           first_err_bxn,
    output logic                  first_err_valid,
    output logic [2:0]            seq_state
);

    localparam int SETTLE_BITS = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_BITS-1:0] SETTLE_LOAD = SETTLE_BITS'(SETTLE_CYCLES - 1);
    // Clean counter wraps on the step that would make it all-ones, so
    // 2^CLEAN_BITS-1 error-free IDLE cycles are needed to forgive retries.
    localparam logic [CLEAN_BITS-1:0] CLEAN_LAST = {{(CLEAN_BITS-1){1'b1}}, 1'b0};

    seq_state_t             state, state_nxt;
    logic [HOLD_BITS-1:0]   hold_cnt, hold_nxt;
    logic [SETTLE_BITS-1:0] settle_cnt, settle_nxt;
    logic [CLEAN_BITS-1:0]  clean_cnt;
    logic                   sync_err_d;
    logic                   err_rise;
    logic                   any_clear;
    logic                   clean_step;
    logic                   clean_wrap;

    assign err_rise   = sync_err & ~sync_err_d;
    assign any_clear  = ttc_resync | vme_clear;
    assign clean_step = (state == ST_IDLE) && !sync_err;
    assign clean_wrap = clean_step && (clean_cnt == CLEAN_LAST);
    assign seq_state  = state;

    // Consecutive error-free IDLE cycles; any error or leaving IDLE restarts it.
    sat_counter #(.WIDTH(CLEAN_BITS)) u_clean_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (any_clear | ~clean_step | clean_wrap),
        .inc     (clean_step),
        .count   (clean_cnt)
    );

    // Auto resets issued; bumped as the sequencer leaves RESET.
    sat_counter #(.WIDTH(RETRY_BITS)) u_retry_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (any_clear | clean_wrap),
        .inc     (state == ST_RESET),
        .count   (retry_count)
    );

    // Rising-edge statistics; ttc_resync outranks vme_clear and keeps the count.
    sat_counter #(.WIDTH(ERR_CNT_W), .MAX_VAL(ERR_CNT_MAX)) u_err_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (vme_clear & ~ttc_resync),
        .inc     (err_rise),
        .count   (err_event_cnt)
    );

    // Next-state and down-counter decode; external clears override everything.
    always_comb begin
        state_nxt  = state;
        hold_nxt   = hold_cnt;
        settle_nxt = settle_cnt;
        case (state)
            ST_IDLE: begin
                if (sync_err && auto_recover_en) begin
                    if (retry_count >= max_retries) begin
                        state_nxt = ST_FAIL;
                    end else begin
                        state_nxt = ST_HOLD;
                        hold_nxt  = holdoff_cnt;
                    end
                end
            end
            ST_HOLD: begin
                if (!sync_err || !auto_recover_en) begin
                    state_nxt = ST_IDLE;
                end else if (hold_cnt == '0) begin
                    state_nxt = ST_RESET;
                end else begin
                    hold_nxt = hold_cnt - 1'b1;
                end
            end
            ST_RESET: begin
                state_nxt  = ST_SETTLE;
                settle_nxt = SETTLE_LOAD;
            end
            ST_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    settle_nxt = settle_cnt - 1'b1;
                end
            end
            ST_FAIL: begin
                state_nxt = ST_FAIL;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (any_clear) begin
            state_nxt  = ST_IDLE;
            hold_nxt   = '0;
            settle_nxt = '0;
        end
    end

    // State register with outputs registered from the next-state decode.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state               <= ST_IDLE;
            hold_cnt            <= '0;
            settle_cnt          <= '0;
            auto_sync_err_reset <= 1'b0;
            recover_busy        <= 1'b0;
            recover_fail        <= 1'b0;
        end else begin
            state               <= state_nxt;
            hold_cnt            <= hold_nxt;
            settle_cnt          <= settle_nxt;
            auto_sync_err_reset <= (state_nxt == ST_RESET);
            recover_busy        <= (state_nxt == ST_HOLD) || (state_nxt == ST_RESET) ||
                                   (state_nxt == ST_SETTLE);
            recover_fail        <= (state_nxt == ST_FAIL);
        end
    end

    // Edge-detect register and first-error bunch crossing capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_err_d      <= 1'b0;
            first_err_bxn   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            sync_err_d <= sync_err;
            if (ttc_resync) begin
                first_err_valid <= 1'b0;
            end else if (vme_clear) begin
                first_err_valid <= 1'b0;
                first_err_bxn   <= '0;
            end else if (err_rise && !first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_bxn   <= bxn_counter;
            end
        end
    end

endmodule
